// File: rtl/ram_nr_w_pkg.sv
// Shared definitions for the multi-read-port register-file RAM:
// sweep FSM state type, reset-mode constants and the address-width helper.
package ram_nr_w_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    localparam int RST_CLEAR = 0;
    localparam int RST_KEEP  = 1;

    // Address width for a given depth, never narrower than one bit.
    function automatic int clog2_min1(input int d);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < d) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_nr_w_s_dff_if.sv
// Bus interface of ram_nr_w_s_dff: chip select, write port, packed read
// addresses and packed registered read data plus the sweep busy flag.
// Parameter values must match those of the RAM it is connected to.
interface ram_nr_w_s_dff_if #(
    parameter int data_width = 8,
    parameter int depth      = 8,
    parameter int num_rd     = 2
);
    import ram_nr_w_pkg::*;

    localparam int aw = clog2_min1(depth);

    logic                         cs_n;
    logic                         wr_n;
    logic [aw-1:0]                wr_addr;
    logic [data_width-1:0]        data_in;
    logic [num_rd*aw-1:0]         rd_addr;
    logic [num_rd*data_width-1:0] data_rd_out;
    logic                         init_busy;

    modport master (
        output cs_n, wr_n, wr_addr, data_in, rd_addr,
        input  data_rd_out, init_busy
    );

    modport slave (
        input  cs_n, wr_n, wr_addr, data_in, rd_addr,
        output data_rd_out, init_busy
    );

endinterface

// File: rtl/ram_rd_port.sv
// One read port of the register-file RAM: range check, optional forwarding
// of the word being written on the same edge, and the output register.
module ram_rd_port
    import ram_nr_w_pkg::*;
#(
    parameter int data_width = 8,
    parameter int depth      = 8,
    parameter int bypass     = 1,
    parameter int aw         = clog2_min1(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_n,
    input  logic                  in_init,
    input  logic                  wr_fire,
    input  logic [aw-1:0]         wr_addr,
    input  logic [data_width-1:0] data_in,
    input  logic [aw-1:0]         rd_addr,
    input  logic [data_width-1:0] mem [depth],
    output logic [data_width-1:0] rd_data
);

    localparam logic [aw:0] depth_lim = (aw + 1)'(depth);

    logic                  in_range;
    logic                  hit;
    logic [data_width-1:0] next_word;

    // Select the word to capture: forwarded write data, stored word or zero.
    always_comb begin
        in_range  = ({1'b0, rd_addr} < depth_lim);
        hit       = (bypass != 0) && wr_fire && (wr_addr == rd_addr);
        next_word = '0;
        if (hit) begin
            next_word = data_in;
        end else if (in_range) begin
            next_word = mem[rd_addr];
        end
    end

    // Output register: cleared by reset, zeroed during the sweep, held while deselected.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (!cs_n) begin
            rd_data <= in_init ? '0 : next_word;
        end
    end

endmodule

// File: rtl/ram_nr_w_s_dff.sv
// Register-file RAM with one write port and num_rd registered read ports.
// After reset an optional sweep writes zero to every entry before user
// writes are accepted; reads during the sweep return zero.
module ram_nr_w_s_dff
    import ram_nr_w_pkg::*;
#(
    parameter int data_width = 8,
    parameter int depth      = 8,
    parameter int num_rd     = 2,
    parameter int rst_mode   = RST_CLEAR,
    parameter int bypass     = 1
) (
    input logic            clk,
    input logic            rst,
    ram_nr_w_s_dff_if.slave bus
);

    localparam int            aw        = clog2_min1(depth);
    localparam logic [aw:0]   depth_lim = (aw + 1)'(depth);
    localparam logic [aw-1:0] last_ptr  = aw'(depth - 1);
    localparam logic [0:0]    S_INIT    = INIT;
    localparam logic [0:0]    S_IDLE    = IDLE;

    logic [data_width-1:0] mem [depth];
    logic [0:0]            state;
    logic [aw-1:0]         ptr;
    logic                  in_init;
    logic                  wr_fire;
    logic [data_width-1:0] rd_q [num_rd];

    // A user write lands only outside the sweep and only to an existing entry.
    always_comb begin
        in_init = (state == S_INIT);
        wr_fire = !in_init && !bus.cs_n && !bus.wr_n &&
                  ({1'b0, bus.wr_addr} < depth_lim);
    end

    // Sweep FSM: walk ptr over every entry once, then hand over to user traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (rst_mode == RST_CLEAR) ? S_INIT : S_IDLE;
            ptr   <= '0;
        end else if (in_init) begin
            if (ptr == last_ptr) begin
                state <= S_IDLE;
                ptr   <= '0;
            end else begin
                ptr <= ptr + aw'(1);
            end
        end
    end

    // Storage array: cleared entry by entry during the sweep, untouched by reset itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_init) begin
                mem[ptr] <= '0;
            end else if (wr_fire) begin
                mem[bus.wr_addr] <= bus.data_in;
            end
        end
    end

    assign bus.init_busy = (rst_mode == RST_CLEAR) ? in_init : 1'b0;

    for (genvar k = 0; k < num_rd; k++) begin : g_rd
        ram_rd_port #(
            .data_width (data_width),
            .depth      (depth),
            .bypass     (bypass),
            .aw         (aw)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .cs_n    (bus.cs_n),
            .in_init (in_init),
            .wr_fire (wr_fire),
            .wr_addr (bus.wr_addr),
            .data_in (bus.data_in),
            .rd_addr (bus.rd_addr[k*aw +: aw]),
            .mem     (mem),
            .rd_data (rd_q[k])
        );
        assign bus.data_rd_out[k*data_width +: data_width] = rd_q[k];
    end

endmodule

// File: doc/ram_nr_w_s_dff.md
# ram_nr_w_s_dff

Parametrised synchronous register-file RAM: one write port, `num_rd` independent read ports, registered read data and optional write-to-read bypass. It succeeds the two-read asynchronous DFF RAM used in the datapath examples. It adds a configurable read-port count, a fully synchronous single-clock interface and a hardware clear sequence after reset. It sits between datapath pipeline stages as a small multi-ported scratch store.

## Interface
- `data_width`, 8: word width, 1..256.
- `depth`, 8: number of words, 2..256; need not be a power of two.
- `num_rd`, 2: number of read ports, 1..8.
- `rst_mode`, 0: 0 = array cleared by an init sweep after reset; 1 = array contents retained through reset.
- `bypass`, 1: 1 = same-cycle write data forwarded to matching reads; 0 = reads return pre-write contents.
- Derived `aw` = max(1, ceil(log2(depth))).

Ports:
- `clk`  in  1  the only clock; all logic updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cs_n`  in  1  active-low chip select; gates both writes and read-register updates.
- `wr_n`  in  1  active-low write enable; qualified by `cs_n`.
- `wr_addr`  in  aw  write address.
- `data_in`  in  data_width  write data.
- `rd_addr`  in  num_rd*aw  packed read addresses; port k uses bits [k*aw +: aw].
- `data_rd_out`  out  num_rd*data_width  packed registered read data; port k uses bits [k*data_width +: data_width].
- `init_busy`  out  1  high while the clear sweep runs.

## Operation
- FSM states: INIT and IDLE.
- Reset, `rst`=1 at an edge:
  - All `data_rd_out` registers go to 0 and the sweep pointer goes to 0.
  - State goes to INIT if `rst_mode`=0, otherwise to IDLE.
  - Array contents are not changed by reset itself.
- INIT:
  - Each cycle, write 0 to mem[ptr], then increment ptr.
  - At ptr = depth-1, write that entry and move to IDLE.
  - User writes are ignored.
  - Read registers load 0 whenever `cs_n`=0.
  - `init_busy` = (state == INIT).
- IDLE, write: if `cs_n`=0 and `wr_n`=0, mem[wr_addr] <= data_in at the edge.
- IDLE, read: if `cs_n`=0, read register k loads mem[rd_addr_k].
  - Bypass: if `bypass`=1 and the same edge writes rd_addr_k, register k loads `data_in` instead.
- `cs_n`=1: no write, and all read registers hold their value.
- Out-of-range addresses (addr ≥ depth): writes are dropped; reads load 0.
- Multiple read ports may use the same address and are independent of each other.
- Reset asserted mid-sweep restarts the sweep at ptr 0.
- `rst_mode`=1: `init_busy` is constant 0.

## Timing
- Read latency is 1 cycle: an address presented before edge t appears on `data_rd_out` after edge t.
- Write-to-read latency:
  - 1 cycle with `bypass`=1 (same-edge forward).
  - 2 cycles with `bypass`=0.
- The sweep takes exactly `depth` cycles after `rst` deasserts. `init_busy` falls after the edge that writes entry depth-1.
- Reset values: `data_rd_out`=0; `init_busy`=1 if `rst_mode`=0, else 0.
- No combinational path from any input to any output.

## Structure
- Shared package `ram_nr_w_pkg` holds:
  - state enum {INIT, IDLE};
  - function `clog2_min1(depth)` for `aw`;
  - the `rst_mode` constants RST_CLEAR=0 and RST_KEEP=1.
- Top level holds the array, write logic and sweep FSM/counter.
- Sub-module `ram_rd_port` covers one read port: address range check, bypass compare/mux, output register with `cs_n` hold and `rst`/INIT zeroing. It is instantiated `num_rd` times with a generate loop.

## Test plan
- Reset with `rst_mode`=0, depth=8: `init_busy`=1 for exactly 8 cycles after `rst` falls; afterwards a read of every address returns 0x00.
- Write 0xA5 to addr 3, then read addr 3 on ports 0 and 1 the next cycle: both ports show 0xA5 one cycle later.
- Same cycle, write 0x3C to addr 5 while port 0 reads addr 5 (old value 0x11):
  - `bypass`=1: port 0 shows 0x3C next cycle;
  - `bypass`=0: port 0 shows 0x11, then 0x3C on a re-read.
- depth=6, num_rd=3: a write to addr 7 is dropped (addrs 0–5 unchanged), and a read of addr 6 returns 0. With `cs_n`=1, outputs hold their previous values while addresses toggle.
- Assert `rst` at sweep cycle 4, release it: the sweep restarts and `init_busy` lasts a full `depth` cycles. A user write attempted during INIT leaves the entry 0.
- `rst_mode`=1: write 0x77 to addr 2, pulse `rst`. `init_busy` stays 0, outputs reset to 0, and a read of addr 2 returns 0x77.
